// File: rtl/pcie_us_fc_sampler.sv
// Transmit flow-control credit sampler: rotates cfg_fc_sel over the available,
// limit and consumed credit views and captures stable snapshots after a settle time.
module pcie_us_fc_sampler #(
    parameter int SETTLE_CYCLES     = 2,
    parameter int ROUND_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic [2:0]                   cfg_fc_sel,
    input  logic [7:0]                   cfg_fc_ph,
    input  logic [11:0]                  cfg_fc_pd,
    input  logic [7:0]                   cfg_fc_nph,
    input  logic [11:0]                  cfg_fc_npd,
    input  logic [7:0]                   cfg_fc_cplh,
    input  logic [11:0]                  cfg_fc_cpld,
    output logic [39:0]                  fc_av,
    output logic [39:0]                  fc_lim,
    output logic [39:0]                  fc_cons,
    output logic                         fc_valid,
    output logic                         fc_update,
    output logic [1:0]                   fc_update_slot,
    output logic [ROUND_COUNT_WIDTH-1:0] round_count
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    localparam logic [1:0] SLOT_AV   = 2'd0;
    localparam logic [1:0] SLOT_LIM  = 2'd1;
    localparam logic [1:0] SLOT_CONS = 2'd2;

    localparam logic [2:0] SEL_AV   = 3'b100;
    localparam logic [2:0] SEL_LIM  = 3'b101;
    localparam logic [2:0] SEL_CONS = 3'b110;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       slot;
    logic [1:0]       slot_nxt;
    logic             capture;
    logic             round_done;
    logic [39:0]      snapshot;

    // Completion credits are deliberately not tracked.
    logic unused_cpl;
    assign unused_cpl = ^{cfg_fc_cplh, cfg_fc_cpld};

    function automatic logic [2:0] sel_of(input logic [1:0] s);
        case (s)
            SLOT_AV:  sel_of = SEL_AV;
            SLOT_LIM: sel_of = SEL_LIM;
            default:  sel_of = SEL_CONS;
        endcase
    endfunction

    assign snapshot   = {cfg_fc_npd, cfg_fc_nph, cfg_fc_pd, cfg_fc_ph};
    assign round_done = capture && (slot == SLOT_CONS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= SETTLE_LOAD;
            slot  <= SLOT_AV;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            slot  <= slot_nxt;
        end
    end

    // A slot, once entered, always runs to its capture edge; enable is only
    // examined at the capture edge so no slot is abandoned half-settled.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        slot_nxt  = slot;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt  = SETTLE_LOAD;
                slot_nxt = SLOT_AV;
                if (enable) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    cnt_nxt  = SETTLE_LOAD;
                    slot_nxt = (slot == SLOT_CONS) ? SLOT_AV : slot + 2'd1;
                    if (!enable) begin
                        state_nxt = ST_IDLE;
                        slot_nxt  = SLOT_AV;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = SETTLE_LOAD;
                slot_nxt  = SLOT_AV;
            end
        endcase
    end

    // Selector follows the next slot so it changes on the capture edge itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_fc_sel <= SEL_AV;
        end else begin
            cfg_fc_sel <= sel_of(slot_nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_av   <= '0;
            fc_lim  <= '0;
            fc_cons <= '0;
        end else if (capture) begin
            case (slot)
                SLOT_AV:  fc_av   <= snapshot;
                SLOT_LIM: fc_lim  <= snapshot;
                default:  fc_cons <= snapshot;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_update      <= 1'b0;
            fc_update_slot <= SLOT_AV;
        end else begin
            fc_update <= capture;
            if (capture) begin
                fc_update_slot <= slot;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_count <= '0;
            fc_valid    <= 1'b0;
        end else if (round_done) begin
            round_count <= round_count + ROUND_COUNT_WIDTH'(1);
            fc_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcie_us_fc_sampler.sv
// Directed bench for pcie_us_fc_sampler: one instance at SETTLE_CYCLES=2 with a
// 4-bit round counter, one at SETTLE_CYCLES=1, each fed by a lagging credit model.
module tb_pcie_us_fc_sampler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // dut0: SETTLE_CYCLES=2, credits lag the selector by 2 edges
    logic        en0 = 1'b0;
    logic [2:0]  sel0;
    logic [2:0]  sel0_d1 = 3'b100;
    logic [2:0]  sel0_d2 = 3'b100;
    logic [7:0]  bias0 = 8'h00;
    logic [39:0] cred0;
    logic [39:0] av0, lim0, cons0;
    logic        valid0, upd0;
    logic [1:0]  uslot0;
    logic [3:0]  rc0;

    // dut1: SETTLE_CYCLES=1, credits lag the selector by 1 edge
    logic        en1 = 1'b0;
    logic [2:0]  sel1;
    logic [2:0]  sel1_d1 = 3'b100;
    logic [39:0] cred1;
    logic [39:0] av1, lim1, cons1;
    logic        valid1, upd1;
    logic [1:0]  uslot1;
    logic [15:0] rc1;

    // Credit model: base values for sel 100, +1 per field for 101, +2 for 110;
    // any other selector yields a poison offset. bias is added to ph only.
    function automatic logic [39:0] fc_model(input logic [2:0] sel, input logic [7:0] bias);
        logic [7:0] o;
        case (sel)
            3'b100:  o = 8'd0;
            3'b101:  o = 8'd1;
            3'b110:  o = 8'd2;
            default: o = 8'h70;
        endcase
        fc_model = {12'h444 + {4'h0, o}, 8'h33 + o, 12'h222 + {4'h0, o}, 8'h11 + o + bias};
    endfunction

    always @(posedge clk) begin
        sel0_d1 <= sel0;
        sel0_d2 <= sel0_d1;
        sel1_d1 <= sel1;
    end

    assign cred0 = fc_model(sel0_d2, bias0);
    assign cred1 = fc_model(sel1_d1, 8'h00);

    pcie_us_fc_sampler #(.SETTLE_CYCLES(2), .ROUND_COUNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .enable(en0), .cfg_fc_sel(sel0),
        .cfg_fc_ph(cred0[7:0]), .cfg_fc_pd(cred0[19:8]),
        .cfg_fc_nph(cred0[27:20]), .cfg_fc_npd(cred0[39:28]),
        .cfg_fc_cplh(8'h5a), .cfg_fc_cpld(12'ha5a),
        .fc_av(av0), .fc_lim(lim0), .fc_cons(cons0),
        .fc_valid(valid0), .fc_update(upd0), .fc_update_slot(uslot0),
        .round_count(rc0)
    );

    pcie_us_fc_sampler #(.SETTLE_CYCLES(1), .ROUND_COUNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .cfg_fc_sel(sel1),
        .cfg_fc_ph(cred1[7:0]), .cfg_fc_pd(cred1[19:8]),
        .cfg_fc_nph(cred1[27:20]), .cfg_fc_npd(cred1[39:28]),
        .cfg_fc_cplh(8'hc3), .cfg_fc_cpld(12'h3c3),
        .fc_av(av1), .fc_lim(lim1), .fc_cons(cons1),
        .fc_valid(valid1), .fc_update(upd1), .fc_update_slot(uslot1),
        .round_count(rc1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] code_of(input int s);
        code_of = (s == 0) ? 3'b100 : (s == 1) ? 3'b101 : 3'b110;
    endfunction

    task automatic chk_reset0(input string tag);
        chk({tag, ".sel"}, 64'(sel0), 64'(3'b100));
        chk({tag, ".av"}, 64'(av0), 64'd0);
        chk({tag, ".lim"}, 64'(lim0), 64'd0);
        chk({tag, ".cons"}, 64'(cons0), 64'd0);
        chk({tag, ".valid"}, 64'(valid0), 64'd0);
        chk({tag, ".upd"}, 64'(upd0), 64'd0);
        chk({tag, ".uslot"}, 64'(uslot0), 64'd0);
        chk({tag, ".rc"}, 64'(rc0), 64'd0);
    endtask

    initial begin
        logic [2:0] exp_sel;
        logic       exp_upd;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset0("rst0");
        chk("rst1.sel", 64'(sel1), 64'(3'b100));
        chk("rst1.valid", 64'(valid1), 64'd0);
        chk("rst1.rc", 64'(rc1), 64'd0);
        rst = 1'b0;

        // SETTLE_CYCLES=1: update every 2 edges, round of 6
        en1 = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            exp_upd = (k > 0) && (k % 2 == 0);
            chk($sformatf("s1.upd k%0d", k), 64'(upd1), 64'(exp_upd));
            if (exp_upd) chk($sformatf("s1.slot k%0d", k), 64'(uslot1), 64'((k / 2 - 1) % 3));
            chk($sformatf("s1.sel k%0d", k), 64'(sel1), 64'(code_of((k / 2) % 3)));
            chk($sformatf("s1.valid k%0d", k), 64'(valid1), 64'(k >= 6));
            chk($sformatf("s1.rc k%0d", k), 64'(rc1), 64'(k >= 6 ? 1 : 0));
            if (k == 6) begin
                chk("s1.av", 64'(av1), 64'(40'h444_33_222_11));
                chk("s1.lim", 64'(lim1), 64'(40'h445_34_223_12));
                chk("s1.cons", 64'(cons1), 64'(40'h446_35_224_13));
            end
        end
        en1 = 1'b0;

        // Basic round on dut0, then enable drop during slot 1 of round 2
        en0 = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (k >= 15) begin
                exp_upd = (k == 15);
                exp_sel = 3'b100;
            end else begin
                exp_upd = (k > 0) && (k % 3 == 0);
                exp_sel = code_of((k / 3) % 3);
            end
            chk($sformatf("b.upd k%0d", k), 64'(upd0), 64'(exp_upd));
            if (exp_upd) chk($sformatf("b.slot k%0d", k), 64'(uslot0), 64'((k / 3 - 1) % 3));
            chk($sformatf("b.sel k%0d", k), 64'(sel0), 64'(exp_sel));
            chk($sformatf("b.valid k%0d", k), 64'(valid0), 64'(k >= 9));
            chk($sformatf("b.rc k%0d", k), 64'(rc0), 64'(k >= 9 ? 1 : 0));
            if (k == 9) begin
                chk("b.av", 64'(av0), 64'(40'h444_33_222_11));
                chk("b.lim", 64'(lim0), 64'(40'h445_34_223_12));
                chk("b.cons", 64'(cons0), 64'(40'h446_35_224_13));
                bias0 = 8'h40;
            end
            if (k == 13) en0 = 1'b0;
        end
        chk("drop.av", 64'(av0), 64'(40'h444_33_222_51));
        chk("drop.lim", 64'(lim0), 64'(40'h445_34_223_52));
        chk("drop.cons", 64'(cons0), 64'(40'h446_35_224_13));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle.sel", 64'(sel0), 64'(3'b100));
        chk("idle.upd", 64'(upd0), 64'd0);
        chk("idle.rc", 64'(rc0), 64'd1);
        chk("idle.valid", 64'(valid0), 64'd1);

        // Re-enable: capture order restarts at slot 0
        bias0 = 8'h80;
        en0 = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            exp_upd = (k > 0) && (k % 3 == 0);
            chk($sformatf("re.upd k%0d", k), 64'(upd0), 64'(exp_upd));
            if (exp_upd) chk($sformatf("re.slot k%0d", k), 64'(uslot0), 64'((k / 3 - 1) % 3));
            if (k == 3) chk("re.av", 64'(av0), 64'(40'h444_33_222_91));
        end
        chk("re.rc", 64'(rc0), 64'd2);

        // Asynchronous reset mid-cycle while in SETTLE
        @(posedge clk);
        #2;
        rst = 1'b1;
        en0 = 1'b0;
        #1;
        chk_reset0("arst");
        @(negedge clk);
        rst = 1'b0;
        bias0 = 8'h00;

        // Round counter wrap with a 4-bit counter
        en0 = 1'b1;
        @(posedge clk);
        repeat (144) @(posedge clk);
        @(negedge clk);
        chk("wrap16.rc", 64'(rc0), 64'd0);
        chk("wrap16.valid", 64'(valid0), 64'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("wrap17.rc", 64'(rc0), 64'd1);
        chk("wrap17.valid", 64'(valid0), 64'd1);
        chk("wrap17.av", 64'(av0), 64'(40'h444_33_222_11));
        en0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
